// File: rtl/key_expansion_stream.sv
`default_nettype none
// ============================================================================
// key_expansion_stream : sequential AES key schedule, one word per cycle,
//                        streaming 128-bit round keys over valid/ready.
// Revision 1.0
// ============================================================================

module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [7:0] c_sbox [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_o = c_sbox[in_i];
endmodule

module key_expansion_stream #(
    parameter int KEY_SIZE = 128
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [KEY_SIZE-1:0] key_i,
    output logic [127:0]        round_key_o,
    output logic                round_key_valid_o,
    input  logic                round_key_ready_i,
    output logic [3:0]          round_index_o,
    output logic                busy_o,
    output logic                done_o
);
    localparam int         c_nk      = KEY_SIZE / 32;
    localparam logic [5:0] c_nk_w    = 6'(c_nk);
    localparam logic [5:0] c_last_w  = 6'(4 * (c_nk + 7) - 1);
    localparam logic [2:0] c_pos_max = 3'(c_nk - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    // Sliding window of the last Nk words: [0] = w[i-Nk], [Nk-1] = w[i-1]
    logic [31:0]  win_q [c_nk];
    logic [31:0]  win_d [c_nk];
    logic [5:0]   idx_q, idx_d;
    logic [2:0]   pos_q, pos_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  acc_q [3];
    logic [31:0]  acc_d [3];
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] rk_q, rk_d;
    logic         valid_q, valid_d;
    logic [3:0]   ridx_q, ridx_d;
    logic         done_q, done_d;

    logic [31:0]  w_prev;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_sub;
    logic [31:0]  w_word;
    logic [7:0]   w_rcon_next;
    logic         w_xfer;
    logic         w_gen;

    assign w_prev      = win_q[c_nk-1];
    assign w_sub_in    = (pos_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign w_rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    assign w_xfer      = valid_q && round_key_ready_i;
    // Hold everything while the next group is complete but the output is still occupied
    assign w_gen       = (state_q == S_EXPAND) &&
                         !((cnt_q == 2'd3) && valid_q && !round_key_ready_i);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (w_sub_in[8*g +: 8]),
            .out_o (w_sub[8*g +: 8])
        );
    end

    always_comb begin
        if (idx_q < c_nk_w) begin
            w_word = win_q[0];
        end else if (pos_q == 3'd0) begin
            w_word = win_q[0] ^ w_sub ^ {rcon_q, 24'h000000};
        end else if ((c_nk == 8) && (pos_q == 3'd4)) begin
            w_word = win_q[0] ^ w_sub;
        end else begin
            w_word = win_q[0] ^ w_prev;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        rcon_d  = rcon_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rk_d    = rk_q;
        valid_d = w_xfer ? 1'b0 : valid_q;
        ridx_d  = ridx_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_EXPAND;
                    for (int k = 0; k < c_nk; k++) begin
                        win_d[k] = key_i[KEY_SIZE-1-32*k -: 32];
                    end
                    idx_d  = '0;
                    pos_d  = '0;
                    rcon_d = 8'h01;
                    cnt_d  = '0;
                end
            end
            S_EXPAND: begin
                if (w_gen) begin
                    for (int k = 0; k < c_nk - 1; k++) begin
                        win_d[k] = win_q[k+1];
                    end
                    win_d[c_nk-1] = w_word;
                    idx_d = idx_q + 6'd1;
                    pos_d = (pos_q == c_pos_max) ? 3'd0 : pos_q + 3'd1;
                    if ((idx_q >= c_nk_w) && (pos_q == 3'd0)) begin
                        rcon_d = w_rcon_next;
                    end
                    if (cnt_q == 2'd3) begin
                        rk_d    = {acc_q[0], acc_q[1], acc_q[2], w_word};
                        valid_d = 1'b1;
                        ridx_d  = idx_q[5:2];
                        cnt_d   = 2'd0;
                    end else begin
                        acc_d[cnt_q] = w_word;
                        cnt_d        = cnt_q + 2'd1;
                    end
                    if (idx_q == c_last_w) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (w_xfer) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            for (int k = 0; k < c_nk; k++) begin
                win_q[k] <= '0;
            end
            idx_q  <= '0;
            pos_q  <= '0;
            rcon_q <= 8'h01;
            for (int k = 0; k < 3; k++) begin
                acc_q[k] <= '0;
            end
            cnt_q   <= '0;
            rk_q    <= '0;
            valid_q <= 1'b0;
            ridx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            rcon_q  <= rcon_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rk_q    <= rk_d;
            valid_q <= valid_d;
            ridx_q  <= ridx_d;
            done_q  <= done_d;
        end
    end

    assign round_key_o       = rk_q;
    assign round_key_valid_o = valid_q;
    assign round_index_o     = ridx_q;
    assign busy_o            = (state_q != S_IDLE);
    assign done_o            = done_q;
endmodule

`default_nettype wire

// File: tb/tb_key_expansion_stream.sv
`default_nettype none
// ============================================================================
// tb_key_expansion_stream : directed FIPS-197 vectors plus randomized keys and
//                           backpressure against a word-level schedule model.
// Revision 1.0
// ============================================================================
module tb_key_expansion_stream;
    localparam logic [255:0] c_k128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] c_k192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] c_k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start_g, ready_g;
    logic [255:0] key_g;
    int           cur;
    int           checks = 0;
    int           failures = 0;

    logic         st0, st1, st2, v0, v1, v2, b0, b1, b2, d0, d1, d2;
    logic [127:0] rk0, rk1, rk2;
    logic [3:0]   ix0, ix1, ix2;

    assign st0 = start_g && (cur == 0);
    assign st1 = start_g && (cur == 1);
    assign st2 = start_g && (cur == 2);

    key_expansion_stream #(.KEY_SIZE(128)) u_k128 (
        .clock_i(clk), .reset_i(rst), .start_i(st0), .key_i(key_g[127:0]),
        .round_key_o(rk0), .round_key_valid_o(v0), .round_key_ready_i(ready_g),
        .round_index_o(ix0), .busy_o(b0), .done_o(d0));
    key_expansion_stream #(.KEY_SIZE(192)) u_k192 (
        .clock_i(clk), .reset_i(rst), .start_i(st1), .key_i(key_g[191:0]),
        .round_key_o(rk1), .round_key_valid_o(v1), .round_key_ready_i(ready_g),
        .round_index_o(ix1), .busy_o(b1), .done_o(d1));
    key_expansion_stream #(.KEY_SIZE(256)) u_k256 (
        .clock_i(clk), .reset_i(rst), .start_i(st2), .key_i(key_g),
        .round_key_o(rk2), .round_key_valid_o(v2), .round_key_ready_i(ready_g),
        .round_index_o(ix2), .busy_o(b2), .done_o(d2));

    logic [127:0] rk;
    logic [3:0]   idx;
    logic         valid, busy, done;
    assign rk    = (cur == 0) ? rk0 : (cur == 1) ? rk1 : rk2;
    assign idx   = (cur == 0) ? ix0 : (cur == 1) ? ix1 : ix2;
    assign valid = (cur == 0) ? v0  : (cur == 1) ? v1  : v2;
    assign busy  = (cur == 0) ? b0  : (cur == 1) ? b1  : b2;
    assign done  = (cur == 0) ? d0  : (cur == 1) ? d1  : d2;

    logic [7:0]   sb [256];
    logic [127:0] exp_rk [15];
    logic [127:0] got_rk [15];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    // S-box derived from the multiplicative inverse in GF(2^8) and the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model(input int nk, input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                w[i] = k[32*(nk-1-i) +: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nk + 6; r++) begin
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 0: ready always high, 1: ready low for 10 cycles at round stall_r, 2: random ready
    task automatic run(input int sel, input logic [255:0] k, input int mode,
                       input int stall_r, input int ign_r, input int rst_r);
        int nk, nr, nw, c, exp_r, stall_left;
        logic prev_valid, prev_xfer, fin, rst_pend, xfer;
        logic [127:0] prev_rk;
        logic [3:0] prev_idx;
        nk = 4 + 2 * sel;
        nr = nk + 6;
        nw = 4 * (nr + 1);
        model(nk, k);
        for (int r = 0; r < 15; r++) got_rk[r] = '0;
        cur = sel; key_g = k; start_g = 1'b1; ready_g = 1'b1;
        @(posedge clk); #1;
        start_g = 1'b0;
        key_g   = rand_key();
        check("busy_on_accept", 128'(busy), 128'(1));
        c = 0; exp_r = 0; stall_left = 0;
        prev_valid = 1'b0; prev_xfer = 1'b0; fin = 1'b0; rst_pend = 1'b0;
        prev_rk = '0; prev_idx = '0;
        while (!fin && c < 1000) begin
            start_g = 1'b0;
            if (rst_pend) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_round_key", rk, 128'(0));
                check("rst_valid", 128'(valid), 128'(0));
                check("rst_index", 128'(idx), 128'(0));
                check("rst_busy", 128'(busy), 128'(0));
                check("rst_done", 128'(done), 128'(0));
                @(posedge clk); #1;
                check("rst_no_done", 128'(done), 128'(0));
                check("rst_still_idle", 128'(busy), 128'(0));
                ready_g = 1'b1;
                return;
            end
            if (prev_xfer && exp_r > nr) begin
                check("done_pulse", 128'(done), 128'(1));
                check("busy_end", 128'(busy), 128'(0));
                if (mode == 0) check("done_cycle", 128'(c), 128'(nw + 1));
                if (mode == 1) check("done_delayed", 128'(c > nw + 1), 128'(1));
                fin = 1'b1;
            end else begin
                check("done_low", 128'(done), 128'(0));
                check("busy_high", 128'(busy), 128'(1));
                if (valid) begin
                    if (prev_valid && !prev_xfer) begin
                        check("hold_key", rk, prev_rk);
                        check("hold_index", 128'(idx), 128'(prev_idx));
                    end else begin
                        check("round_index", 128'(idx), 128'(exp_r));
                        check("round_key", rk, exp_rk[exp_r]);
                        got_rk[exp_r] = rk;
                        if (mode == 0) check("valid_cycle", 128'(c), 128'(4 * exp_r + 4));
                        if (mode == 1 && exp_r == stall_r) stall_left = 10;
                        if (exp_r == ign_r) begin
                            start_g = 1'b1;
                            key_g   = rand_key();
                        end
                    end
                end
                if (mode == 2) begin
                    ready_g = ($urandom_range(0, 3) != 0);
                end else begin
                    ready_g = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
                xfer = valid && ready_g;
                if (xfer && exp_r == rst_r) rst_pend = 1'b1;
                if (xfer) exp_r++;
                prev_xfer  = xfer;
                prev_valid = valid;
                prev_rk    = rk;
                prev_idx   = idx;
                @(posedge clk); #1;
                c++;
            end
        end
        check("stream_complete", 128'(fin), 128'(1));
        ready_g = 1'b1;
        if (fin) begin
            @(posedge clk); #1;
            check("done_one_cycle", 128'(done), 128'(0));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] k;
        int s;
        build_sbox();
        rst = 1'b1; start_g = 1'b0; ready_g = 1'b1; key_g = '0; cur = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cur = i;
            #1;
            check("reset_round_key", rk, 128'(0));
            check("reset_valid", 128'(valid), 128'(0));
            check("reset_index", 128'(idx), 128'(0));
            check("reset_busy", 128'(busy), 128'(0));
            check("reset_done", 128'(done), 128'(0));
        end

        run(0, c_k128, 0, -1, -1, -1);
        check("fips128_r0", got_rk[0], c_k128[127:0]);
        check("fips128_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips128_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run(1, c_k192, 0, -1, -1, -1);
        check("fips192_r12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

        run(2, c_k256, 0, -1, -1, -1);
        check("fips256_r14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        run(0, c_k128, 1, 2, -1, -1);
        check("stall_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("stall_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run(0, c_k128, 0, -1, 5, 7);

        k = rand_key();
        run(0, k, 0, -1, -1, -1);
        check("newkey_r0", got_rk[0], k[127:0]);

        for (int it = 0; it < 6; it++) begin
            s = $urandom_range(0, 2);
            k = rand_key();
            run(s, k, 2, -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
